switch_debouncer: RTL
=====================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz), number of consecutive stable clocks required to accept a new switch level; legal range 2..2^20.
REQ-002 SHALL have parameter CNT_W, default 18, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port i_clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_switch_1_raw, input, 1, raw asynchronous bouncing switch 1 pin.
REQ-006 SHALL have port i_switch_2_raw, input, 1, raw asynchronous bouncing switch 2 pin.
REQ-007 SHALL have port o_switch_1, output, 1, debounced level of switch 1; drives the LED blinker's i_switch_1.
REQ-008 SHALL have port o_switch_2, output, 1, debounced level of switch 2; drives the LED blinker's i_switch_2.
REQ-009 SHALL have port o_rise, output, 2, per-channel one-cycle pulse on accepted 0->1 transition (bit 0 = switch 1).
REQ-010 SHALL have port o_fall, output, 2, per-channel one-cycle pulse on accepted 1->0 transition.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic; no raw input feeds combinational logic.
REQ-012 Each channel SHALL run an independent 4-state FSM: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-013 STABLE_LO: sync=1 -> CHECK_HI with counter loaded to 1; else stay, counter 0.
REQ-014 CHECK_HI: sync=0 -> STABLE_LO, counter 0 (bounce rejected); sync=1 and counter=DEBOUNCE_CYCLES-1 -> STABLE_HI; else counter+1.
REQ-015 STABLE_HI/CHECK_LO SHALL mirror REQ-013/014 with levels inverted.
REQ-016 Debounced output SHALL be registered and equal 1 exactly in STABLE_HI and CHECK_LO.
REQ-017 Accepted transition SHALL occur on the rising edge where the synchronized input has held the new level for DEBOUNCE_CYCLES consecutive edges; pin-to-output latency = DEBOUNCE_CYCLES+2 clocks.
REQ-018 Any reversion of the synchronized input before acceptance SHALL discard the count; a later attempt restarts from 1, never resumes.
REQ-019 o_rise/o_fall bit SHALL be high for exactly the one cycle in which the matching debounced output changes, registered, aligned with that change.
REQ-020 o_rise and o_fall of one channel SHALL never be high together; consecutive pulses on a channel SHALL be at least DEBOUNCE_CYCLES cycles apart.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on both channels SHALL both be accepted on the same cycle.
REQ-022 Counter SHALL saturate-free: it never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Reset
REQ-023 While i_reset=0: synchronizer flops 0, FSM STABLE_LO, counter 0, o_switch_1=o_switch_2=0, o_rise=o_fall=2'b00, asynchronously.
REQ-024 Reset asserted mid-CHECK SHALL abort the pending transition with no pulse emitted.
REQ-025 After release with a raw input held at 1, that channel SHALL assert output and rise pulse after DEBOUNCE_CYCLES+2 clocks.

Structure
REQ-026 FSM state encodings and default DEBOUNCE_CYCLES SHALL live in the shared include file used by the LED blinker design.
REQ-027 Per-channel logic (synchronizer, FSM, counter, pulse regs) SHALL be sub-module debounce_channel, instantiated twice.

Verification (DEBOUNCE_CYCLES=4, 100 ps clock)
REQ-028 Raw 1 held 20 cycles -> o_switch_1 rises exactly 6 clocks after pin change; o_rise[0] high 1 cycle; o_switch_2 stays 0.
REQ-029 Raw glitch 1 for 3 cycles then 0 -> o_switch_1 stays 0, no pulses.
REQ-030 Bounce 1,0,1,0 per cycle then steady 1 -> single rise, 6 clocks after final steady edge.
REQ-031 Both raws 0->1 same cycle -> both outputs rise same cycle, o_rise=2'b11 one cycle; then both 1->0 -> o_fall=2'b11.
REQ-032 Reset asserted 2 cycles into CHECK_HI -> outputs 0 immediately, no pulse; after release with raw still 1 -> rise 6 clocks later.
REQ-033 Connect to LED blinker, step switches 00,01,10,11 each held 10 cycles -> blinker inputs follow with 6-cycle lag, no intermediate glitches.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer and the LED blinker it feeds.
// Holds the per-channel FSM state encoding and the default debounce
// parameters, so both designs agree on them.
package switch_debouncer_pkg;

  // 5 ms at 50 MHz.
  localparam int unsigned DebounceCyclesDefault = 250000;
  localparam int unsigned CntWDefault           = 18;

  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StCheckHi  = 2'b01,
    StStableHi = 2'b10,
    StCheckLo  = 2'b11
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM with a
// stability counter, registered debounced level and one-cycle edge pulses.
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   raw_i   - raw asynchronous switch pin
//   level_o - debounced level (registered)
//   rise_o  - one-cycle pulse aligned with an accepted 0->1 change
//   fall_o  - one-cycle pulse aligned with an accepted 1->0 change
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_W           = CntWDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStableLo: begin
        if (sync2_q) begin
          state_d = StCheckHi;
          cnt_d   = CntOne;
        end else begin
          cnt_d   = '0;
        end
      end
      StCheckHi: begin
        if (!sync2_q) begin
          // Bounce: discard the count, a later attempt restarts from 1.
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CntOne;
        end
      end
      StStableHi: begin
        if (!sync2_q) begin
          state_d = StCheckLo;
          cnt_d   = CntOne;
        end else begin
          cnt_d   = '0;
        end
      end
      StCheckLo: begin
        if (sync2_q) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase

    // Level and pulses are derived from the next state so the registered
    // outputs change on the same edge the FSM accepts the transition.
    level_d = (state_d == StStableHi) || (state_d == StCheckLo);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StStableLo;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Two-channel switch debouncer feeding the LED blinker.
//
// Ports:
//   i_clk          - system clock, rising edge
//   i_reset        - asynchronous active-low reset
//   i_switch_1_raw - raw bouncing switch 1 pin
//   i_switch_2_raw - raw bouncing switch 2 pin
//   o_switch_1     - debounced switch 1 level
//   o_switch_2     - debounced switch 2 level
//   o_rise[1:0]    - accepted 0->1 pulse per channel (bit 0 = switch 1)
//   o_fall[1:0]    - accepted 1->0 pulse per channel (bit 0 = switch 1)
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_W           = CntWDefault
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_switch_1_raw,
  input  logic       i_switch_2_raw,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic [1:0] o_rise,
  output logic [1:0] o_fall
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch1 (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .raw_i  (i_switch_1_raw),
    .level_o(o_switch_1),
    .rise_o (o_rise[0]),
    .fall_o (o_fall[0])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch2 (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .raw_i  (i_switch_2_raw),
    .level_o(o_switch_2),
    .rise_o (o_rise[1]),
    .fall_o (o_fall[1])
  );

endmodule
